mem_arbiter: RTL and testbench

Shares one single-ported memory/bus slave between the instruction-fetch port (ibus, read-only) and the load/store port (dbus, read/write with byte select). It sits between the IFU/LSU and the memory interface. It grants one master at a time, latches that master's request, and runs a valid/ready request phase followed by a response phase. It returns data with a one-cycle ack and raises a pipeline hold while any request is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/arb_grant_sel.sv | 28 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and grant encoding for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned MemBus      = 32;
  localparam int unsigned ByteSel     = 4;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbReq  = 2'b01,
    ArbResp = 2'b10,
    ArbAck  = 2'b11
  } arb_state_e;

  typedef enum logic {
    ArbGntI = 1'b0,
    ArbGntD = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant selection between ibus and dbus.
// ARB_RR_EN selects round-robin; otherwise dbus has fixed priority.
module arb_grant_sel
  import mem_arbiter_pkg::*;
(
  input  logic     ibus_req_i,
  input  logic     dbus_req_i,
`ifdef ARB_RR_EN
  input  arb_gnt_e last_i,
`endif
  output arb_gnt_e gnt_o
);

  always_comb begin
    gnt_o = dbus_req_i ? ArbGntD : ArbGntI;
`ifdef ARB_RR_EN
    // On a conflict favour whichever master was not served last.
    if (ibus_req_i && dbus_req_i) begin
      gnt_o = (last_i == ArbGntI) ? ArbGntD : ArbGntI;
    end
`else
    if (ibus_req_i && !dbus_req_i) begin
      gnt_o = ArbGntI;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (ibus/dbus) arbiter in front of a single-ported valid/ready memory slave.
// Define ARB_RR_EN for round-robin arbitration; default is dbus fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = MemBus,
  parameter int unsigned SEL_W  = ByteSel
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ibus_req_i,
  input  logic [ADDR_W-1:0] ibus_addr_i,
  output logic [DATA_W-1:0] ibus_data_o,
  output logic              ibus_ack_o,
  input  logic              dbus_req_i,
  input  logic              dbus_we_i,
  input  logic [ADDR_W-1:0] dbus_addr_i,
  input  logic [DATA_W-1:0] dbus_data_i,
  input  logic [SEL_W-1:0]  dbus_sel_i,
  output logic [DATA_W-1:0] dbus_data_o,
  output logic              dbus_ack_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [SEL_W-1:0]  mem_sel_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              hold_o
);

  arb_state_e        state_q;
  arb_gnt_e          gnt_q;
  arb_gnt_e          gnt_sel;
  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] ibus_data_q;
  logic [DATA_W-1:0] dbus_data_q;
  logic              ibus_ack_q;
  logic              dbus_ack_q;

  // In round-robin mode the latched grant doubles as the last-served pointer.
  arb_grant_sel u_grant_sel (
    .ibus_req_i (ibus_req_i),
    .dbus_req_i (dbus_req_i),
`ifdef ARB_RR_EN
    .last_i     (gnt_q),
`endif
    .gnt_o      (gnt_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ArbIdle;
      gnt_q       <= ArbGntI;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      ibus_data_q <= '0;
      dbus_data_q <= '0;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
    end else begin
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
      unique case (state_q)
        ArbIdle: begin
          if (ibus_req_i || dbus_req_i) begin
            gnt_q   <= gnt_sel;
            valid_q <= 1'b1;
            state_q <= ArbReq;
            if (gnt_sel == ArbGntD) begin
              we_q    <= dbus_we_i;
              addr_q  <= dbus_addr_i;
              wdata_q <= dbus_data_i;
              sel_q   <= dbus_sel_i;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= ibus_addr_i;
              wdata_q <= '0;
              sel_q   <= '1;
            end
          end
        end
        ArbReq: begin
          if (mem_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ArbResp;
          end
        end
        ArbResp: begin
          if (mem_rvalid_i) begin
            state_q <= ArbAck;
            if (gnt_q == ArbGntD) begin
              dbus_data_q <= we_q ? '0 : mem_rdata_i;
              dbus_ack_q  <= 1'b1;
            end else begin
              ibus_data_q <= mem_rdata_i;
              ibus_ack_q  <= 1'b1;
            end
          end
        end
        ArbAck: begin
          state_q <= ArbIdle;
        end
        default: begin
          state_q <= ArbIdle;
        end
      endcase
    end
  end

  assign mem_valid_o = valid_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sel_o   = sel_q;
  assign ibus_data_o = ibus_data_q;
  assign dbus_data_o = dbus_data_q;
  assign ibus_ack_o  = ibus_ack_q;
  assign dbus_ack_o  = dbus_ack_q;

  assign hold_o = (ibus_req_i & ~ibus_ack_q) | (dbus_req_i & ~dbus_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; follows ARB_RR_EN for the conflict test.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_req_i;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_data_o;
  logic        ibus_ack_o;
  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_data_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_data_o;
  logic        dbus_ack_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        hold_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ibus_req_i   (ibus_req_i),
    .ibus_addr_i  (ibus_addr_i),
    .ibus_data_o  (ibus_data_o),
    .ibus_ack_o   (ibus_ack_o),
    .dbus_req_i   (dbus_req_i),
    .dbus_we_i    (dbus_we_i),
    .dbus_addr_i  (dbus_addr_i),
    .dbus_data_i  (dbus_data_i),
    .dbus_sel_i   (dbus_sel_i),
    .dbus_data_o  (dbus_data_o),
    .dbus_ack_o   (dbus_ack_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_sel_o    (mem_sel_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .hold_o       (hold_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change and outputs settle here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, {31'd0, mem_valid_o}, 32'd0);
    check({tag, ".we"}, {31'd0, mem_we_o}, 32'd0);
    check({tag, ".addr"}, mem_addr_o, 32'd0);
    check({tag, ".wdata"}, mem_wdata_o, 32'd0);
    check({tag, ".sel"}, {28'd0, mem_sel_o}, 32'd0);
    check({tag, ".iack"}, {31'd0, ibus_ack_o}, 32'd0);
    check({tag, ".dack"}, {31'd0, dbus_ack_o}, 32'd0);
    check({tag, ".idata"}, ibus_data_o, 32'd0);
    check({tag, ".ddata"}, dbus_data_o, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        exp_d;

    rst_n = 1'b0;
    ibus_req_i = 1'b0; ibus_addr_i = '0;
    dbus_req_i = 1'b0; dbus_we_i = 1'b0; dbus_addr_i = '0; dbus_data_i = '0; dbus_sel_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset values
    tick(); tick();
    check_all_zero("rst");
    check("rst.hold", {31'd0, hold_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ibus read, immediate ready/rvalid: ack in cycle 3
    ibus_req_i = 1'b1; ibus_addr_i = 32'h8000_0000;
    mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0413;
    settle();
    check("ird.c0.hold", {31'd0, hold_o}, 32'd1);
    tick();
    check("ird.c1.valid", {31'd0, mem_valid_o}, 32'd1);
    check("ird.c1.addr", mem_addr_o, 32'h8000_0000);
    check("ird.c1.sel", {28'd0, mem_sel_o}, 32'hF);
    check("ird.c1.we", {31'd0, mem_we_o}, 32'd0);
    tick();
    check("ird.c2.valid", {31'd0, mem_valid_o}, 32'd0);
    check("ird.c2.ack", {31'd0, ibus_ack_o}, 32'd0);
    tick();
    check("ird.c3.ack", {31'd0, ibus_ack_o}, 32'd1);
    check("ird.c3.data", ibus_data_o, 32'h0000_0413);
    check("ird.c3.hold", {31'd0, hold_o}, 32'd0);
    ibus_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    check("ird.c4.ack", {31'd0, ibus_ack_o}, 32'd0);
    check("ird.c4.data", ibus_data_o, 32'h0000_0413);

    // dbus byte store with ready delayed two cycles: ack in cycle 5
    dbus_req_i = 1'b1; dbus_we_i = 1'b1; dbus_addr_i = 32'h8000_1003;
    dbus_data_i = 32'hAB00_0000; dbus_sel_i = 4'b1000; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("sb.c0.hold", {31'd0, hold_o}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_ready_i = 1'b1;
      check($sformatf("sb.c%0d.valid", c), {31'd0, mem_valid_o}, 32'd1);
      check($sformatf("sb.c%0d.addr", c), mem_addr_o, 32'h8000_1003);
      check($sformatf("sb.c%0d.wdata", c), mem_wdata_o, 32'hAB00_0000);
      check($sformatf("sb.c%0d.sel", c), {28'd0, mem_sel_o}, 32'h8);
      check($sformatf("sb.c%0d.we", c), {31'd0, mem_we_o}, 32'd1);
    end
    tick();
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b1;
    check("sb.c4.valid", {31'd0, mem_valid_o}, 32'd0);
    check("sb.c4.ack", {31'd0, dbus_ack_o}, 32'd0);
    tick();
    check("sb.c5.ack", {31'd0, dbus_ack_o}, 32'd1);
    check("sb.c5.data", dbus_data_o, 32'd0);
    check("sb.c5.iack", {31'd0, ibus_ack_o}, 32'd0);
    check("sb.c5.idata", ibus_data_o, 32'h0000_0413);
    dbus_req_i = 1'b0; dbus_we_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();

    // Spurious rvalid in IDLE and REQ must be ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    check("sp.idle.dack", {31'd0, dbus_ack_o}, 32'd0);
    check("sp.idle.iack", {31'd0, ibus_ack_o}, 32'd0);
    dbus_req_i = 1'b1; dbus_we_i = 1'b0; dbus_addr_i = 32'h0000_0100; dbus_sel_i = 4'hF;
    tick();
    check("sp.c1.valid", {31'd0, mem_valid_o}, 32'd1);
    tick();
    check("sp.c2.valid", {31'd0, mem_valid_o}, 32'd1);
    check("sp.c2.dack", {31'd0, dbus_ack_o}, 32'd0);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hCAFE_F00D;
    check("sp.c3.dack", {31'd0, dbus_ack_o}, 32'd0);
    check("sp.c3.ddata", dbus_data_o, 32'd0);
    tick();
    mem_rvalid_i = 1'b1;
    check("sp.c4.dack", {31'd0, dbus_ack_o}, 32'd0);
    tick();
    check("sp.c5.dack", {31'd0, dbus_ack_o}, 32'd1);
    check("sp.c5.ddata", dbus_data_o, 32'hCAFE_F00D);
    dbus_req_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();

    // Reset restores the ibus-last pointer before the conflict test
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Simultaneous requests held for four transactions
    ibus_req_i = 1'b1; ibus_addr_i = 32'h0000_0040;
    dbus_req_i = 1'b1; dbus_we_i = 1'b0; dbus_addr_i = 32'h0000_0200; dbus_sel_i = 4'hF;
    mem_ready_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) dbus_req_i = 1'b0;
`ifdef ARB_RR_EN
      exp_d = (k == 4) ? 1'b0 : ((k % 2) == 0);
`else
      exp_d = (k != 4);
`endif
      exp_addr = exp_d ? 32'h0000_0200 : 32'h0000_0040;
      mem_rdata_i = 32'h1000_0000 + k;
      tick();
      check($sformatf("cf%0d.addr", k), mem_addr_o, exp_addr);
      tick();
      tick();
      check($sformatf("cf%0d.dack", k), {31'd0, dbus_ack_o}, {31'd0, exp_d});
      check($sformatf("cf%0d.iack", k), {31'd0, ibus_ack_o}, {31'd0, ~exp_d});
      check($sformatf("cf%0d.data", k), exp_d ? dbus_data_o : ibus_data_o,
            32'h1000_0000 + k);
      tick();
    end
    ibus_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();

    // Reset while in RESP: late rvalid discarded, all outputs back to zero
    dbus_req_i = 1'b1; dbus_we_i = 1'b0; dbus_addr_i = 32'h0000_0300;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    tick();
    tick();
    check("mr.c2.valid", {31'd0, mem_valid_o}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dbus_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b1;
    check_all_zero("mr.c3");
    tick();
    check("mr.c4.dack", {31'd0, dbus_ack_o}, 32'd0);
    check("mr.c4.valid", {31'd0, mem_valid_o}, 32'd0);
    check("mr.c4.ddata", dbus_data_o, 32'd0);
    mem_rvalid_i = 1'b0;
    tick();

    // hold_o for a dbus load with immediate slave
    dbus_req_i = 1'b1; mem_ready_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick(); else settle();
      check($sformatf("hold.c%0d", c), {31'd0, hold_o}, (c < 3) ? 32'd1 : 32'd0);
    end
    dbus_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
